// File: rtl/carpma_tanim_pkg.sv
// Shared definitions for the arithmetic units: multiply op codes, multiplier FSM states
// and the op-code normaliser used by both the multiplier and the execute stage.
package carpma_tanim_pkg;

   localparam logic [3:0] OP_MUL    = 4'h1;
   localparam logic [3:0] OP_MULH   = 4'h2;
   localparam logic [3:0] OP_MULHSU = 4'h4;
   localparam logic [3:0] OP_MULHU  = 4'h8;

   localparam logic [3:0] SON_ADIM  = 4'd15;

   typedef enum logic [1:0] {
      BOSTA  = 2'd0,
      CARP   = 2'd1,
      DUZELT = 2'd2,
      SONUC  = 2'd3
   } durum_t;

   // Anything that is not one of the three high-word codes behaves as MUL.
   function automatic logic [3:0] islev_coz(input logic [3:0] kod);
      case (kod)
         OP_MULH, OP_MULHSU, OP_MULHU: return kod;
         default:                      return OP_MUL;
      endcase
   endfunction

endpackage

// File: rtl/carpici.sv
// Iterative radix-4 sign-magnitude multiplier: 16 add/shift steps, then a sign fix and
// word select, giving a fixed 17-cycle busy period per request.
module carpim_adimi (
   input  logic [63:0] birikim,
   input  logic [31:0] buyukluk,
   input  logic [1:0]  bitler,
   input  logic [3:0]  adim,
   output logic [63:0] sonraki_birikim
);

   logic [63:0] genis;
   logic [63:0] kat;

   always_comb begin
      genis = {32'd0, buyukluk};
      case (bitler)
         2'd0:    kat = '0;
         2'd1:    kat = genis;
         2'd2:    kat = genis << 1;
         default: kat = (genis << 1) + genis;
      endcase
      sonraki_birikim = birikim + (kat << {adim, 1'b0});
   end

endmodule

module carpici
   import carpma_tanim_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  islev_kodu_i,
   input  logic [31:0] islec0_i,
   input  logic [31:0] islec1_i,
   input  logic        islem_gecerli_i,
   output logic        mesgul_o,
   output logic        carpim_gecerli_o,
   output logic [31:0] carpim_o
);

   durum_t      durum_q, durum_d;
   logic [3:0]  islev_q;
   logic [31:0] carpilan_q, carpan_q;
   logic        isaret_q;
   logic [63:0] birikim_q, birikim_d;
   logic [3:0]  adim_q;

   logic        kabul;
   logic [3:0]  islev_yeni;
   logic        isaretli0, isaretli1;
   logic [31:0] buyukluk0, buyukluk1;
   logic        isaret_yeni;
   logic [63:0] tam_sonuc;

   assign kabul = islem_gecerli_i && ((durum_q == BOSTA) || (durum_q == SONUC));

   // Operand magnitudes and product sign are resolved before latching, so the
   // iteration itself only ever sees unsigned values.
   always_comb begin
      islev_yeni  = islev_coz(islev_kodu_i);
      isaretli0   = (islev_yeni != OP_MULHU);
      isaretli1   = (islev_yeni == OP_MUL) || (islev_yeni == OP_MULH);
      buyukluk0   = (isaretli0 && islec0_i[31]) ? (~islec0_i + 32'd1) : islec0_i;
      buyukluk1   = (isaretli1 && islec1_i[31]) ? (~islec1_i + 32'd1) : islec1_i;
      isaret_yeni = (isaretli0 && islec0_i[31]) ^ (isaretli1 && islec1_i[31]);
      tam_sonuc   = isaret_q ? (~birikim_q + 64'd1) : birikim_q;
   end

   carpim_adimi u_adim (
      .birikim         (birikim_q),
      .buyukluk        (carpilan_q),
      .bitler          (carpan_q[1:0]),
      .adim            (adim_q),
      .sonraki_birikim (birikim_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         durum_q <= BOSTA;
      end else begin
         durum_q <= durum_d;
      end
   end

   always_comb begin
      durum_d = durum_q;
      case (durum_q)
         BOSTA:   if (kabul) durum_d = CARP;
         CARP:    if (adim_q == SON_ADIM) durum_d = DUZELT;
         DUZELT:  durum_d = SONUC;
         SONUC:   durum_d = kabul ? CARP : BOSTA;
         default: durum_d = BOSTA;
      endcase
   end

   always_comb begin
      mesgul_o = (durum_q == CARP) || (durum_q == DUZELT);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         islev_q          <= '0;
         carpilan_q       <= '0;
         carpan_q         <= '0;
         isaret_q         <= 1'b0;
         birikim_q        <= '0;
         adim_q           <= '0;
         carpim_o         <= '0;
         carpim_gecerli_o <= 1'b0;
      end else begin
         carpim_gecerli_o <= (durum_q == DUZELT);
         if (kabul) begin
            islev_q    <= islev_yeni;
            carpilan_q <= buyukluk0;
            carpan_q   <= buyukluk1;
            isaret_q   <= isaret_yeni;
            birikim_q  <= '0;
            adim_q     <= '0;
         end else if (durum_q == CARP) begin
            birikim_q <= birikim_d;
            carpan_q  <= carpan_q >> 2;
            adim_q    <= adim_q + 4'd1;
         end
         if (durum_q == DUZELT) begin
            carpim_o <= (islev_q == OP_MUL) ? tam_sonuc[31:0] : tam_sonuc[63:32];
         end
      end
   end

endmodule

// File: tb/tb_carpici.sv
// Self-checking bench for carpici: directed corner cases plus randomized operations
// compared against a plain 64-bit arithmetic reference model.
module tb_carpici;

   logic        clk_i;
   logic        rst_ni;
   logic [3:0]  islev_kodu_i;
   logic [31:0] islec0_i;
   logic [31:0] islec1_i;
   logic        islem_gecerli_i;
   logic        mesgul_o;
   logic        carpim_gecerli_o;
   logic [31:0] carpim_o;

   int checkCount = 0;
   int errorCount = 0;

   carpici dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .islev_kodu_i    (islev_kodu_i),
      .islec0_i        (islec0_i),
      .islec1_i        (islec1_i),
      .islem_gecerli_i (islem_gecerli_i),
      .mesgul_o        (mesgul_o),
      .carpim_gecerli_o(carpim_gecerli_o),
      .carpim_o        (carpim_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Reference product straight from the arithmetic definition of each op.
   function automatic logic [31:0] refMul(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] ua64, ub64, p;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ub   = longint'({32'd0, b});
      ua64 = {32'd0, a};
      ub64 = {32'd0, b};
      case (code)
         4'h2:    begin p = sa * sb;     return p[63:32]; end
         4'h4:    begin p = sa * ub;     return p[63:32]; end
         4'h8:    begin p = ua64 * ub64; return p[63:32]; end
         default: begin p = sa * sb;     return p[31:0];  end
      endcase
   endfunction

   task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
      islev_kodu_i    = code;
      islec0_i        = a;
      islec1_i        = b;
      islem_gecerli_i = 1'b1;
      @(posedge clk_i); #1;
      islem_gecerli_i = 1'b0;
      islec0_i        = $urandom;
      islec1_i        = $urandom;
      islev_kodu_i    = 4'($urandom);
   endtask

   // Called just after the accept edge (or startEdges edges later); waits for the pulse.
   task automatic waitResult(input string tag, input logic [31:0] expected, input int startEdges);
      int edges;
      int busy;
      edges = startEdges;
      busy  = startEdges;
      while (!carpim_gecerli_o && edges < 40) begin
         if (mesgul_o) busy++;
         @(posedge clk_i); #1;
         edges++;
      end
      checkOutput({tag, "_latency"}, 32'(edges), 32'd17);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd17);
      checkOutput({tag, "_result"}, carpim_o, expected);
   endtask

   task automatic runOp(input string tag, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expected);
      applyStimulus(code, a, b);
      waitResult(tag, expected, 0);
      @(posedge clk_i); #1;
      checkOutput({tag, "_pulse_end"}, {31'd0, carpim_gecerli_o}, 32'd0);
      checkOutput({tag, "_hold"}, carpim_o, expected);
   endtask

   initial begin
      logic [3:0]  codes [5];
      logic [3:0]  code;
      logic [31:0] a, b, expected;

      codes[0] = 4'h1; codes[1] = 4'h2; codes[2] = 4'h4; codes[3] = 4'h8; codes[4] = 4'h0;
      rst_ni          = 1'b0;
      islem_gecerli_i = 1'b0;
      islev_kodu_i    = 4'h0;
      islec0_i        = '0;
      islec1_i        = '0;
      #1;
      checkOutput("reset_result", carpim_o, 32'd0);
      checkOutput("reset_valid", {31'd0, carpim_gecerli_o}, 32'd0);
      checkOutput("reset_busy", {31'd0, mesgul_o}, 32'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      runOp("mul_7x6", 4'h1, 32'd7, 32'd6, 32'h0000002A);
      runOp("mulh_m1", 4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      runOp("mul_m1", 4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      runOp("mulhu_max", 4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      runOp("mulhsu_max", 4'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      runOp("mulh_min", 4'h2, 32'h80000000, 32'h80000000, 32'h40000000);
      runOp("mul_zero", 4'h1, 32'h12345678, 32'd0, 32'd0);

      // Back-to-back: second request presented while the first result is valid.
      applyStimulus(4'h1, 32'd1000, 32'd3000);
      waitResult("b2b_first", 32'd3000000, 0);
      applyStimulus(4'h8, 32'h80000000, 32'h4);
      checkOutput("b2b_accept_busy", {31'd0, mesgul_o}, 32'd1);
      checkOutput("b2b_accept_valid", {31'd0, carpim_gecerli_o}, 32'd0);
      waitResult("b2b_second", 32'h00000002, 0);

      // A request pulsed mid-iteration must be ignored.
      applyStimulus(4'h1, 32'd12, 32'd11);
      repeat (5) begin @(posedge clk_i); #1; end
      islev_kodu_i    = 4'h8;
      islec0_i        = 32'hFFFFFFFF;
      islec1_i        = 32'hFFFFFFFF;
      islem_gecerli_i = 1'b1;
      @(posedge clk_i); #1;
      islem_gecerli_i = 1'b0;
      waitResult("ignore_carp", 32'd132, 6);
      @(posedge clk_i); #1;
      checkOutput("ignore_no_accept", {31'd0, mesgul_o}, 32'd0);

      // Reset in the middle of the iteration aborts without a pulse.
      applyStimulus(4'h1, 32'd9, 32'd9);
      repeat (8) begin @(posedge clk_i); #1; end
      rst_ni = 1'b0;
      #1;
      checkOutput("midrst_result", carpim_o, 32'd0);
      checkOutput("midrst_valid", {31'd0, carpim_gecerli_o}, 32'd0);
      checkOutput("midrst_busy", {31'd0, mesgul_o}, 32'd0);
      repeat (2) begin
         @(posedge clk_i); #1;
         checkOutput("midrst_hold_valid", {31'd0, carpim_gecerli_o}, 32'd0);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      runOp("op0_3x5", 4'h0, 32'd3, 32'd5, 32'h0000000F);

      for (int i = 0; i < 40; i++) begin
         code = codes[$urandom_range(0, 4)];
         if ($urandom_range(0, 5) == 0) code = 4'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: a = 32'h80000000;
            1: b = 32'hFFFFFFFF;
            2: b = 32'd0;
            3: a = 32'h7FFFFFFF;
            default: ;
         endcase
         expected = refMul(code, a, b);
         runOp($sformatf("rand%0d_op%0h", i, code), code, a, b, expected);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
